// File: rtl/mem_xfer_seq.sv
// mem_xfer_seq: ARM memory-stage transfer sequencer for single, halfword and LDM/STM transfers.
// Define MEMSEQ_ALIGN_CHK_EN to turn on start-address alignment faults.
module mem_xfer_seq #(
    parameter int ADDR_W = 32,
    parameter int NREG   = 16,
    parameter int IDX_W  = 4
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              START,
    input  logic [31:0]       OPCODE,
    input  logic [ADDR_W-1:0] BASE,
    input  logic [ADDR_W-1:0] OFFSET,
    input  logic              MEM_READY,
    output logic              BUSY,
    output logic              MEM_EN,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic              READ_MEM,
    output logic [1:0]        B_HW_W,
    output logic              SIGNED,
    output logic [IDX_W-1:0]  REG_IDX,
    output logic              WB_EN,
    output logic [ADDR_W-1:0] WB_ADDR,
    output logic              DONE,
    output logic              ALIGN_FAULT
);
    localparam int CNT_W = $clog2(NREG + 1);

    typedef enum logic [1:0] {IDLE, SETUP, XFER, FINISH} state_t;

    state_t            state_q, state_d;
    logic [27:0]       op_q, op_d;
    logic [ADDR_W-1:0] base_q, base_d, off_q, off_d;
    logic [ADDR_W-1:0] addr_q, addr_d, wb_addr_q, wb_addr_d;
    logic [NREG-1:0]   list_q, list_d, list_nx;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [1:0]        size_q, size_d;
    logic              rd_q, rd_d, sgn_q, sgn_d, blk_q, blk_d, wb_q, wb_d, fault_q, fault_d;

    logic              is_blk, is_sgl, is_hw, valid, fault, s_sgn;
    logic [1:0]        s_size;
    logic [ADDR_W-1:0] off, eff, n4, up, dn, s_addr;
    logic              unused_op;

    function automatic logic [IDX_W-1:0] lowest(input logic [NREG-1:0] l);
        lowest = '0;
        for (int i = NREG - 1; i >= 0; i--)
            if (l[i]) lowest = IDX_W'(i);
    endfunction

    function automatic logic [CNT_W-1:0] popcnt(input logic [NREG-1:0] l);
        popcnt = '0;
        for (int i = 0; i < NREG; i++) popcnt = popcnt + CNT_W'(l[i]);
    endfunction

    assign unused_op = ^{OPCODE[31:28], op_q[19:16]};

    // Decode of the latched instruction, consumed in SETUP.
    assign is_blk = op_q[27:25] == 3'b100;
    assign is_sgl = op_q[27:26] == 2'b01;
    assign is_hw  = op_q[27:25] == 3'b000 && op_q[7] && op_q[4] && op_q[6:5] != 2'b00;
    assign off    = is_sgl ? (op_q[25] ? off_q : ADDR_W'(op_q[11:0]))
                           : (op_q[22] ? ADDR_W'({op_q[11:8], op_q[3:0]}) : off_q);
    assign eff    = op_q[23] ? base_q + off : base_q - off;
    assign n4     = ADDR_W'(popcnt(op_q[NREG-1:0])) << 2;
    assign up     = base_q + n4;
    assign dn     = base_q - n4;
    assign s_addr = is_blk ? (op_q[23] ? base_q + ADDR_W'({op_q[24], 2'b00})
                                       : dn + ADDR_W'({!op_q[24], 2'b00}))
                           : (op_q[24] ? eff : base_q);
    assign s_size = is_blk ? 2'b10 : is_sgl ? (op_q[22] ? 2'b00 : 2'b10) : {1'b0, op_q[5]};
    assign s_sgn  = is_hw && op_q[6];
    assign valid  = is_blk ? |op_q[NREG-1:0] : is_sgl || is_hw;
`ifdef MEMSEQ_ALIGN_CHK_EN
    assign fault  = valid && (s_size == 2'b10 ? s_addr[1:0] != 2'b00 : s_size == 2'b01 && s_addr[0]);
`else
    assign fault  = 1'b0;
`endif

    assign list_nx = list_q & ~(NREG'(1) << idx_q);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        base_d    = base_q;
        off_d     = off_q;
        addr_d    = addr_q;
        wb_addr_d = wb_addr_q;
        list_d    = list_q;
        idx_d     = idx_q;
        size_d    = size_q;
        rd_d      = rd_q;
        sgn_d     = sgn_q;
        blk_d     = blk_q;
        wb_d      = wb_q;
        fault_d   = fault_q;
        case (state_q)
            IDLE: if (START) begin
                op_d    = OPCODE[27:0];
                base_d  = BASE;
                off_d   = OFFSET;
                state_d = SETUP;
            end
            SETUP: begin
                addr_d    = s_addr;
                size_d    = s_size;
                sgn_d     = s_sgn;
                rd_d      = op_q[20];
                blk_d     = is_blk;
                list_d    = op_q[NREG-1:0];
                idx_d     = is_blk ? lowest(op_q[NREG-1:0]) : IDX_W'(op_q[15:12]);
                wb_addr_d = is_blk ? (op_q[23] ? up : dn) : eff;
                wb_d      = valid && !fault && (is_blk ? op_q[21] : op_q[21] || !op_q[24]);
                fault_d   = fault;
                state_d   = valid && !fault ? XFER : FINISH;
            end
            XFER: if (MEM_READY) begin
                if (!blk_q || list_nx == '0) state_d = FINISH;
                else begin
                    addr_d = addr_q + ADDR_W'(4);
                    idx_d  = lowest(list_nx);
                    list_d = list_nx;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= IDLE;
            op_q      <= '0;
            base_q    <= '0;
            off_q     <= '0;
            addr_q    <= '0;
            wb_addr_q <= '0;
            list_q    <= '0;
            idx_q     <= '0;
            size_q    <= '0;
            rd_q      <= 1'b0;
            sgn_q     <= 1'b0;
            blk_q     <= 1'b0;
            wb_q      <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            base_q    <= base_d;
            off_q     <= off_d;
            addr_q    <= addr_d;
            wb_addr_q <= wb_addr_d;
            list_q    <= list_d;
            idx_q     <= idx_d;
            size_q    <= size_d;
            rd_q      <= rd_d;
            sgn_q     <= sgn_d;
            blk_q     <= blk_d;
            wb_q      <= wb_d;
            fault_q   <= fault_d;
        end
    end

    assign BUSY        = state_q != IDLE;
    assign MEM_EN      = state_q == XFER;
    assign DONE        = state_q == FINISH;
    assign WB_EN       = state_q == FINISH && wb_q;
    assign ALIGN_FAULT = state_q == FINISH && fault_q;
    assign MEM_ADDR    = addr_q;
    assign WB_ADDR     = wb_addr_q;
    assign READ_MEM    = rd_q;
    assign B_HW_W      = size_q;
    assign SIGNED      = sgn_q;
    assign REG_IDX     = idx_q;
endmodule

// File: tb/tb_mem_xfer_seq.sv
// tb_mem_xfer_seq: directed checks of mem_xfer_seq against hand-computed transfer sequences.
module tb_mem_xfer_seq;
    logic        CLK = 1'b0;
    logic        RESET_N, START, MEM_READY;
    logic [31:0] OPCODE, BASE, OFFSET;
    logic        BUSY, MEM_EN, READ_MEM, SIGNED, WB_EN, DONE, ALIGN_FAULT;
    logic [31:0] MEM_ADDR, WB_ADDR;
    logic [1:0]  B_HW_W;
    logic [3:0]  REG_IDX;
    int          tests = 0;
    int          fails = 0;
    int          stm_idx [5] = '{4, 5, 6, 7, 14};

    localparam logic [31:0] LDMIA = 32'hE8B0002A;
    localparam logic [31:0] STMDB = 32'hE92D40F0;
    localparam logic [31:0] LDRB  = 32'hE5512003;

    mem_xfer_seq dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .OPCODE(OPCODE), .BASE(BASE),
        .OFFSET(OFFSET), .MEM_READY(MEM_READY), .BUSY(BUSY), .MEM_EN(MEM_EN),
        .MEM_ADDR(MEM_ADDR), .READ_MEM(READ_MEM), .B_HW_W(B_HW_W), .SIGNED(SIGNED),
        .REG_IDX(REG_IDX), .WB_EN(WB_EN), .WB_ADDR(WB_ADDR), .DONE(DONE),
        .ALIGN_FAULT(ALIGN_FAULT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic go(input logic [31:0] op, input logic [31:0] b);
        OPCODE = op;
        BASE   = b;
        START  = 1'b1;
        tick();
        START  = 1'b0;
    endtask

    task automatic acc(input string tag, input logic [31:0] a, input logic [31:0] idx,
                       input logic [31:0] rd, input logic [31:0] sz);
        chk({tag, "_en"}, MEM_EN, 1);
        chk({tag, "_addr"}, MEM_ADDR, a);
        chk({tag, "_idx"}, REG_IDX, idx);
        chk({tag, "_rd"}, READ_MEM, rd);
        chk({tag, "_sz"}, B_HW_W, sz);
    endtask

    task automatic done_chk(input string tag, input logic wb, input logic [31:0] wba);
        chk({tag, "_done"}, DONE, 1);
        chk({tag, "_busy"}, BUSY, 1);
        chk({tag, "_noen"}, MEM_EN, 0);
        chk({tag, "_wben"}, WB_EN, wb);
        if (wb) chk({tag, "_wbaddr"}, WB_ADDR, wba);
    endtask

    initial begin
        RESET_N = 1'b1; START = 1'b0; OPCODE = '0; BASE = '0; OFFSET = '0; MEM_READY = 1'b1;
        #2 RESET_N = 1'b0;
        #2;
        chk("rst_ctl", {BUSY, MEM_EN, READ_MEM, SIGNED, WB_EN, DONE, ALIGN_FAULT, B_HW_W, REG_IDX}, 0);
        chk("rst_addr", MEM_ADDR, 0);
        chk("rst_wb", WB_ADDR, 0);
        tick(); tick();
        RESET_N = 1'b1;
        tick();
        go(LDMIA, 32'h100);
        chk("ldm_busy1", BUSY, 1);
        chk("ldm_setup_noen", MEM_EN, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            acc("ldm", 32'h100 + 32'(4 * k), 32'(2 * k + 1), 1, 2);
        end
        tick();
        done_chk("ldm", 1'b1, 32'h10C);
        tick();
        chk("ldm_idle", BUSY, 0);
        chk("ldm_done_pulse", DONE, 0);
        go(STMDB, 32'h1000);
        for (int k = 0; k < 5; k++) begin
            tick();
            acc("stm", 32'hFEC + 32'(4 * k), 32'(stm_idx[k]), 0, 2);
        end
        tick();
        done_chk("stm", 1'b1, 32'hFEC);
        tick();
        chk("stm_idle", BUSY, 0);
        go(LDRB, 32'h200);
        tick();
        acc("ldrb", 32'h1FD, 2, 1, 0);
        chk("ldrb_sgn", SIGNED, 0);
        tick();
        done_chk("ldrb", 1'b0, 0);
        tick();
        go(32'hE0D230F4, 32'h300);
        tick();
        acc("ldrsh", 32'h300, 3, 1, 1);
        chk("ldrsh_sgn", SIGNED, 1);
        tick();
        done_chk("ldrsh", 1'b1, 32'h304);
        tick();
        go(32'hE8B00000, 32'h400);
        chk("empty_busy", BUSY, 1);
        tick();
        done_chk("empty", 1'b0, 0);
        tick();
        chk("empty_idle", BUSY, 0);
        go(32'hE0812003, 32'h500);
        tick();
        done_chk("nop", 1'b0, 0);
        tick();
        go(LDMIA, 32'h100);
        tick();
        acc("stl0", 32'h100, 1, 1, 2);
        tick();
        acc("stl1", 32'h104, 3, 1, 2);
        MEM_READY = 1'b0;
        OPCODE = LDRB; BASE = 32'h200; START = 1'b1;
        tick();
        START = 1'b0;
        acc("stl_hold_a", 32'h104, 3, 1, 2);
        tick();
        acc("stl_hold_b", 32'h104, 3, 1, 2);
        tick();
        acc("stl_hold_c", 32'h104, 3, 1, 2);
        MEM_READY = 1'b1;
        tick();
        acc("stl2", 32'h108, 5, 1, 2);
        tick();
        done_chk("stl", 1'b1, 32'h10C);
        tick();
        chk("stl_idle", BUSY, 0);
        tick();
        chk("stl_dropped_start", BUSY, 0);
        go(STMDB, 32'h1000);
        tick();
        acc("rst_mid0", 32'hFEC, 4, 0, 2);
        tick();
        RESET_N = 1'b0;
        #1;
        chk("rst_mid_ctl", {BUSY, MEM_EN, READ_MEM, SIGNED, WB_EN, DONE, ALIGN_FAULT, B_HW_W, REG_IDX}, 0);
        chk("rst_mid_addr", MEM_ADDR, 0);
        chk("rst_mid_wb", WB_ADDR, 0);
        tick();
        RESET_N = 1'b1;
        tick();
        chk("rst_mid_nowb", WB_EN, 0);
        chk("rst_mid_idle", BUSY, 0);
        go(LDRB, 32'h200);
        tick();
        acc("post_rst", 32'h1FD, 2, 1, 0);
        tick();
        done_chk("post_rst", 1'b0, 0);
        tick();
        go(32'hE5910002, 32'h200);
        tick();
`ifdef MEMSEQ_ALIGN_CHK_EN
        chk("mis_noen", MEM_EN, 0);
        chk("mis_done", DONE, 1);
        chk("mis_fault", ALIGN_FAULT, 1);
        chk("mis_nowb", WB_EN, 0);
        tick();
        chk("mis_idle", BUSY, 0);
        chk("mis_pulse", ALIGN_FAULT, 0);
`else
        acc("mis", 32'h202, 0, 1, 2);
        chk("mis_nofault", ALIGN_FAULT, 0);
        tick();
        done_chk("mis", 1'b0, 0);
        chk("mis_nofault_done", ALIGN_FAULT, 0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
